bcd_time_counter: RTL
=====================

Name: bcd_time_counter

Overview:
- 24-hour time-of-day counter that produces the six BCD digits (hour1, hour0, min1, min0, sec1, sec0) consumed by the hourly chime block and the display mux.
- Divides the system clock down to a 1 Hz advance and cascades the carries through seconds, minutes and hours.
- Provides a set mode for manual hour/minute adjustment and a seconds-clear input.

Parameters:
- CLK_HZ, 100_000_000, system clock cycles per second advance. Must be ≥2. Benches use 4.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- run  input  1  level; 1 = time advances, 0 = paused
- set_mode  input  1  level; 1 = counting frozen, inc inputs enabled
- inc_hour  input  1  single-cycle pulse (already debounced); hours +1 in set mode
- inc_min  input  1  single-cycle pulse (already debounced); minutes +1 in set mode
- clr_sec  input  1  single-cycle pulse; seconds → 00 and prescaler → 0, in any mode
- hour1  output  4  hours tens, BCD 0–2
- hour0  output  4  hours units, BCD 0–9
- min1  output  4  minutes tens, BCD 0–5
- min0  output  4  minutes units, BCD 0–9
- sec1  output  4  seconds tens, BCD 0–5
- sec0  output  4  seconds units, BCD 0–9
- sec_tick  output  1  one-cycle pulse in the cycle the digits show a newly advanced second

Behaviour:
- Reset (rst_n=0, asynchronous): all digits 0 (00:00:00), prescaler 0, sec_tick 0. Counting resumes on the first clk edge after deassertion.
- Prescaler:
  - Counts 0..CLK_HZ-1 while running (run=1 and set_mode=0).
  - The edge at CLK_HZ-1 wraps it to 0 and advances seconds on that same edge.
  - Held at its current value when paused (run=0, set_mode=0).
  - Forced to 0 while set_mode=1.
- All outputs are registered. Digits and sec_tick update on the same edge. First advance after reset occurs CLK_HZ cycles after the first running edge.
- Advance cascade, all on one edge:
  - sec0 9→0 carries into sec1. sec1:sec0 59→00 carries into minutes.
  - min 59→00 carries into hours.
  - hour 23→00 (hour1=2, hour0=3 → 0,0). hour0 9→0 carries into hour1 when hours <20.
- Invariant: no digit ever holds an illegal value (hour1>2, hours>23, min1/sec1>5, any digit>9).
- Mode priority: set_mode > run.
  - set_mode=1: seconds and prescaler frozen (prescaler 0). inc_hour: hours +1 mod 24. inc_min: minutes +1 mod 60, with no carry into hours.
  - inc_hour and inc_min in the same cycle: both applied independently.
  - set_mode=0: inc_hour and inc_min are ignored.
- clr_sec:
  - Seconds → 00 and prescaler → 0 on that edge, in any mode. Minutes and hours are unchanged.
  - Wins over a simultaneous advance edge: no advance, no carry, sec_tick=0.
- sec_tick is 1 only on the advance edge, and never in set mode or while paused.
- Leaving set_mode: the prescaler starts from 0, so the next advance is CLK_HZ running cycles later.
- Reset asserted mid-count or mid-set takes effect immediately. Pending pulses are lost.

Test Plan:
- Reset, then run=1 with CLK_HZ=4 for 4 cycles → digits 00:00:01, sec_tick high exactly 1 cycle. After 40 cycles → 00:00:10 (sec1=1, sec0=0).
- Preset 23:59:59 via set mode, then run one second → 00:00:00 on a single edge with sec_tick=1. Digits are never observed as 24 or 60.
- set_mode=1 at 12:59:30:
  - inc_min → 12:00:30 (hour unchanged).
  - inc_hour ×12 → 00:00:30.
  - inc_hour and inc_min in the same cycle → 01:01:30.
  - Seconds never change during this sequence.
- run=0 for 100 cycles at 05:06:07 → digits constant, sec_tick 0. Set run=1 → advance to 05:06:08 after the remaining prescaler count.
- clr_sec on the exact edge where the prescaler = CLK_HZ-1 at 10:20:45 → 10:20:00, sec_tick 0. Next advance CLK_HZ cycles later → 10:20:01.
- Assert rst_n low asynchronously mid-count at 08:30:15 → outputs 00:00:00 immediately, before the next clk edge.

Source files
------------

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 24-hour time-of-day counter with BCD digit outputs.
// A prescaler divides the system clock to a one-second advance which ripples
// through seconds, minutes and hours on a single edge. A set mode freezes
// counting and lets hours/minutes be stepped manually; clr_sec zeroes the
// seconds and re-phases the prescaler in any mode.
module bcd_time_counter #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       set_mode,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic       clr_sec,
    output logic [3:0] hour1,
    output logic [3:0] hour0,
    output logic [3:0] min1,
    output logic [3:0] min0,
    output logic [3:0] sec1,
    output logic [3:0] sec0,
    output logic       sec_tick
);

    // Prescaler width; a 1-bit counter is enough for the CLK_HZ == 2 corner.
    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------

    // Two-digit BCD increment that wraps 59 -> 00 (seconds and minutes).
    function automatic logic [7:0] bcd_inc_sexa(input logic [3:0] tens,
                                                input logic [3:0] units);
        logic [7:0] result;
        result = {tens, units};
        if (units == 4'd9) begin
            result[3:0] = 4'd0;
            result[7:4] = (tens == 4'd5) ? 4'd0 : tens + 4'd1;
        end else begin
            result[3:0] = units + 4'd1;
        end
        return result;
    endfunction

    // Two-digit BCD increment that wraps 23 -> 00 (hours). The units digit
    // only carries into the tens at 09 and 19; 23 is caught before that.
    function automatic logic [7:0] bcd_inc_hour(input logic [3:0] tens,
                                                input logic [3:0] units);
        logic [7:0] result;
        result = {tens, units};
        if (tens == 4'd2 && units == 4'd3) begin
            result = 8'h00;
        end else if (units == 4'd9) begin
            result[3:0] = 4'd0;
            result[7:4] = tens + 4'd1;
        end else begin
            result[3:0] = units + 4'd1;
        end
        return result;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_reg, presc_next;
    logic [3:0]    hour1_reg, hour1_next;
    logic [3:0]    hour0_reg, hour0_next;
    logic [3:0]    min1_reg,  min1_next;
    logic [3:0]    min0_reg,  min0_next;
    logic [3:0]    sec1_reg,  sec1_next;
    logic [3:0]    sec0_reg,  sec0_next;
    logic          sec_tick_reg, sec_tick_next;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic running;      // time is advancing (set mode overrides run)
    logic presc_last;   // prescaler sits on its terminal count
    logic advance;      // this edge moves the time forward one second
    logic sec_wrap;     // seconds currently read 59
    logic min_wrap;     // minutes currently read 59
    logic min_step;     // minutes increment on this edge
    logic hour_step;    // hours increment on this edge

    assign running    = run & ~set_mode;
    assign presc_last = (presc_reg == PRESC_LAST);
    // clr_sec beats an advance landing on the same edge: no step, no tick.
    assign advance    = running & presc_last & ~clr_sec;
    assign sec_wrap   = (sec1_reg == 4'd5) && (sec0_reg == 4'd9);
    assign min_wrap   = (min1_reg == 4'd5) && (min0_reg == 4'd9);
    // In set mode minutes and hours step independently, so a minute wrap
    // from inc_min never reaches the hours.
    assign min_step   = (advance & sec_wrap) | (set_mode & inc_min);
    assign hour_step  = (advance & sec_wrap & min_wrap) | (set_mode & inc_hour);

    // Prescaler: cleared in set mode or by clr_sec, counts while running,
    // holds while paused.
    always_comb begin
        presc_next = presc_reg;
        if (set_mode || clr_sec) begin
            presc_next = '0;
        end else if (running) begin
            if (presc_last) begin
                presc_next = '0;
            end else begin
                presc_next = presc_reg + PRESC_ONE;
            end
        end
    end

    // Seconds: zeroed by clr_sec, otherwise stepped only on an advance.
    always_comb begin
        sec1_next = sec1_reg;
        sec0_next = sec0_reg;
        if (clr_sec) begin
            sec1_next = 4'd0;
            sec0_next = 4'd0;
        end else if (advance) begin
            {sec1_next, sec0_next} = bcd_inc_sexa(sec1_reg, sec0_reg);
        end
    end

    // Minutes: stepped by the seconds carry or by inc_min in set mode.
    always_comb begin
        min1_next = min1_reg;
        min0_next = min0_reg;
        if (min_step) begin
            {min1_next, min0_next} = bcd_inc_sexa(min1_reg, min0_reg);
        end
    end

    // Hours: stepped by the minutes carry or by inc_hour in set mode.
    always_comb begin
        hour1_next = hour1_reg;
        hour0_next = hour0_reg;
        if (hour_step) begin
            {hour1_next, hour0_next} = bcd_inc_hour(hour1_reg, hour0_reg);
        end
    end

    // sec_tick marks the cycle in which the digits show a new second.
    always_comb begin
        sec_tick_next = advance;
    end

    // State registers with asynchronous active-low reset to 00:00:00.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg    <= '0;
            hour1_reg    <= 4'd0;
            hour0_reg    <= 4'd0;
            min1_reg     <= 4'd0;
            min0_reg     <= 4'd0;
            sec1_reg     <= 4'd0;
            sec0_reg     <= 4'd0;
            sec_tick_reg <= 1'b0;
        end else begin
            presc_reg    <= presc_next;
            hour1_reg    <= hour1_next;
            hour0_reg    <= hour0_next;
            min1_reg     <= min1_next;
            min0_reg     <= min0_next;
            sec1_reg     <= sec1_next;
            sec0_reg     <= sec0_next;
            sec_tick_reg <= sec_tick_next;
        end
    end

    assign hour1    = hour1_reg;
    assign hour0    = hour0_reg;
    assign min1     = min1_reg;
    assign min0     = min0_reg;
    assign sec1     = sec1_reg;
    assign sec0     = sec0_reg;
    assign sec_tick = sec_tick_reg;

endmodule
